// File: rtl/pong_pkg.sv
// Shared constants, state encoding and helpers for the pong game engine.
package pong_pkg;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned SCORE_W   = 4;
    localparam int unsigned AI_STEP   = 2;

    localparam int unsigned H_ACTIVE_DEF     = 640;
    localparam int unsigned V_ACTIVE_DEF     = 480;
    localparam int unsigned PADDLE_X_DEF     = 16;
    localparam int unsigned PADDLE_W_DEF     = 8;
    localparam int unsigned PADDLE_H_DEF     = 64;
    localparam int unsigned BALL_SIZE_DEF    = 8;
    localparam int unsigned PADDLE_STEP_DEF  = 4;
    localparam int unsigned BALL_STEP_DEF    = 2;
    localparam int unsigned SERVE_FRAMES_DEF = 60;

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_MISS  = 2'd2
    } state_t;

    // Zero-extend a screen coordinate into the signed working width.
    function automatic logic signed [COORD_W:0] to_s11(input logic [COORD_W-1:0] v);
        return $signed({1'b0, v});
    endfunction

endpackage

// File: rtl/pong_paddle_ctrl.sv
// Paddle mover: steps up/down once per frame tick, clamped to [0, MAX_POS].
module pong_paddle_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned STEP     = 4,
    parameter int unsigned MAX_POS  = 416,
    parameter int unsigned INIT_POS = 208
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               up,
    input  logic               down,
    output logic [COORD_W-1:0] pos
);

    localparam logic signed [COORD_W:0] S_STEP = (COORD_W+1)'(STEP);
    localparam logic signed [COORD_W:0] S_MAX  = (COORD_W+1)'(MAX_POS);

    logic signed [COORD_W:0] raised;
    logic signed [COORD_W:0] lowered;
    logic [COORD_W-1:0]      pos_nxt;

    assign raised  = to_s11(pos) - S_STEP;
    assign lowered = to_s11(pos) + S_STEP;

    // Both or neither key held leaves the paddle where it is.
    always_comb begin
        pos_nxt = pos;
        if (up && !down) begin
            pos_nxt = (raised < 11'sd0) ? '0 : COORD_W'(raised);
        end else if (down && !up) begin
            pos_nxt = (lowered > S_MAX) ? COORD_W'(MAX_POS) : COORD_W'(lowered);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos <= COORD_W'(INIT_POS);
        end else if (tick) begin
            pos <= pos_nxt;
        end
    end

endmodule

// File: rtl/pong_game_engine.sv
// Per-frame pong world update: paddles, ball, serve/miss sequencing and scores.
// Define PONG_AI_PADDLE_EN for a tracking right paddle; otherwise the right edge is a wall.
module pong_game_engine
    import pong_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
    parameter int unsigned PADDLE_X     = PADDLE_X_DEF,
    parameter int unsigned PADDLE_W     = PADDLE_W_DEF,
    parameter int unsigned PADDLE_H     = PADDLE_H_DEF,
    parameter int unsigned BALL_SIZE    = BALL_SIZE_DEF,
    parameter int unsigned PADDLE_STEP  = PADDLE_STEP_DEF,
    parameter int unsigned BALL_STEP    = BALL_STEP_DEF,
    parameter int unsigned SERVE_FRAMES = SERVE_FRAMES_DEF
) (
    input  logic               inClock,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               raket_up,
    input  logic               raket_down,
    output logic [COORD_W-1:0] paddle_y,
    output logic [COORD_W-1:0] ai_y,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic [SCORE_W-1:0] miss_cnt,
    output logic [SCORE_W-1:0] win_cnt,
    output logic [1:0]         state
);

    localparam int unsigned SW          = COORD_W + 1;
    localparam int unsigned PADDLE_MAX  = V_ACTIVE - PADDLE_H;
    localparam int unsigned PADDLE_INIT = PADDLE_MAX / 2;
    localparam int unsigned BALL_X0     = (H_ACTIVE - BALL_SIZE) / 2;
    localparam int unsigned BALL_Y0     = (V_ACTIVE - BALL_SIZE) / 2;
    localparam int unsigned BALL_X_MAX  = H_ACTIVE - BALL_SIZE;
    localparam int unsigned BALL_Y_MAX  = V_ACTIVE - BALL_SIZE;
    localparam int unsigned LEFT_FACE   = PADDLE_X + PADDLE_W;
    localparam int unsigned SERVE_W     = $clog2(SERVE_FRAMES + 1);

    localparam logic signed [SW-1:0] S_BSTEP = SW'(BALL_STEP);
    localparam logic signed [SW-1:0] S_BSIZE = SW'(BALL_SIZE);
    localparam logic signed [SW-1:0] S_PH    = SW'(PADDLE_H);
    localparam logic signed [SW-1:0] S_XMAX  = SW'(BALL_X_MAX);
    localparam logic signed [SW-1:0] S_YMAX  = SW'(BALL_Y_MAX);
    localparam logic signed [SW-1:0] S_LFACE = SW'(LEFT_FACE);

    state_t               state_q, state_nxt;
    logic [SERVE_W-1:0]   serve_q, serve_nxt;
    logic                 dx, dy, dx_nxt, dy_nxt;
    logic                 left_lost, left_lost_nxt;
    logic [COORD_W-1:0]   bx_nxt, by_nxt;
    logic [SCORE_W-1:0]   miss_nxt, win_nxt;
    logic signed [SW-1:0] bx_s, by_s, nx, ny;
    logic                 overlap_l;

    assign state = state_q;
    assign bx_s  = to_s11(ball_x);
    assign by_s  = to_s11(ball_y);
    assign nx    = dx ? (bx_s + S_BSTEP) : (bx_s - S_BSTEP);
    assign ny    = dy ? (by_s + S_BSTEP) : (by_s - S_BSTEP);

    assign overlap_l = ((by_s + S_BSIZE) > to_s11(paddle_y)) &&
                       (by_s < (to_s11(paddle_y) + S_PH));

    pong_paddle_ctrl #(
        .STEP     (PADDLE_STEP),
        .MAX_POS  (PADDLE_MAX),
        .INIT_POS (PADDLE_INIT)
    ) u_player (
        .clk   (inClock),
        .reset (reset),
        .tick  (frame_tick),
        .up    (raket_up),
        .down  (raket_down),
        .pos   (paddle_y)
    );

`ifdef PONG_AI_PADDLE_EN
    localparam int unsigned RIGHT_FACE = H_ACTIVE - PADDLE_X - PADDLE_W - BALL_SIZE;
    localparam logic signed [SW-1:0] S_RFACE  = SW'(RIGHT_FACE);
    localparam int                   AI_OFS   = int'(BALL_SIZE / 2) - int'(PADDLE_H / 2);
    localparam logic signed [SW-1:0] S_AI_OFS = SW'(AI_OFS);

    logic signed [SW-1:0] ai_target;
    logic                 overlap_r;

    // Steer so the paddle centre follows the ball centre.
    assign ai_target = by_s + S_AI_OFS;
    assign overlap_r = ((by_s + S_BSIZE) > to_s11(ai_y)) &&
                       (by_s < (to_s11(ai_y) + S_PH));

    pong_paddle_ctrl #(
        .STEP     (AI_STEP),
        .MAX_POS  (PADDLE_MAX),
        .INIT_POS (PADDLE_INIT)
    ) u_ai (
        .clk   (inClock),
        .reset (reset),
        .tick  (frame_tick),
        .up    (ai_target < to_s11(ai_y)),
        .down  (ai_target > to_s11(ai_y)),
        .pos   (ai_y)
    );
`else
    assign ai_y = COORD_W'(PADDLE_INIT);
`endif

    // Next-state and next-world for one frame step.
    always_comb begin
        state_nxt     = state_q;
        serve_nxt     = serve_q;
        bx_nxt        = ball_x;
        by_nxt        = ball_y;
        dx_nxt        = dx;
        dy_nxt        = dy;
        left_lost_nxt = left_lost;
        miss_nxt      = miss_cnt;
        win_nxt       = win_cnt;
        case (state_q)
            ST_SERVE: begin
                bx_nxt = COORD_W'(BALL_X0);
                by_nxt = COORD_W'(BALL_Y0);
                if (serve_q == SERVE_W'(SERVE_FRAMES - 1)) begin
                    state_nxt = ST_PLAY;
                    serve_nxt = '0;
                end else begin
                    serve_nxt = serve_q + SERVE_W'(1);
                end
            end
            ST_PLAY: begin
                if (ny <= 11'sd0) begin
                    by_nxt = '0;
                    dy_nxt = 1'b1;
                end else if (ny >= S_YMAX) begin
                    by_nxt = COORD_W'(BALL_Y_MAX);
                    dy_nxt = 1'b0;
                end else begin
                    by_nxt = COORD_W'(ny);
                end
                bx_nxt = COORD_W'(nx);
                // Hit tests use pre-tick ball and paddle positions.
                if (!dx && nx <= S_LFACE && bx_s >= S_LFACE && overlap_l) begin
                    bx_nxt = COORD_W'(LEFT_FACE);
                    dx_nxt = 1'b1;
                end else if (!dx && nx <= 11'sd0) begin
                    bx_nxt        = '0;
                    state_nxt     = ST_MISS;
                    left_lost_nxt = 1'b1;
                    if (miss_cnt != '1) miss_nxt = miss_cnt + SCORE_W'(1);
`ifdef PONG_AI_PADDLE_EN
                end else if (dx && nx >= S_RFACE && bx_s <= S_RFACE && overlap_r) begin
                    bx_nxt = COORD_W'(RIGHT_FACE);
                    dx_nxt = 1'b0;
                end else if (dx && nx >= S_XMAX) begin
                    bx_nxt        = COORD_W'(BALL_X_MAX);
                    state_nxt     = ST_MISS;
                    left_lost_nxt = 1'b0;
                    if (win_cnt != '1) win_nxt = win_cnt + SCORE_W'(1);
`else
                end else if (dx && nx >= S_XMAX) begin
                    bx_nxt = COORD_W'(BALL_X_MAX);
                    dx_nxt = 1'b0;
`endif
                end
            end
            ST_MISS: begin
                bx_nxt    = COORD_W'(BALL_X0);
                by_nxt    = COORD_W'(BALL_Y0);
                dx_nxt    = left_lost;
                serve_nxt = '0;
                state_nxt = ST_SERVE;
            end
            default: begin
                state_nxt = ST_SERVE;
                serve_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge inClock) begin
        if (reset) begin
            state_q   <= ST_SERVE;
            serve_q   <= '0;
            ball_x    <= COORD_W'(BALL_X0);
            ball_y    <= COORD_W'(BALL_Y0);
            dx        <= 1'b1;
            dy        <= 1'b1;
            left_lost <= 1'b0;
            miss_cnt  <= '0;
            win_cnt   <= '0;
        end else if (frame_tick) begin
            state_q   <= state_nxt;
            serve_q   <= serve_nxt;
            ball_x    <= bx_nxt;
            ball_y    <= by_nxt;
            dx        <= dx_nxt;
            dy        <= dy_nxt;
            left_lost <= left_lost_nxt;
            miss_cnt  <= miss_nxt;
            win_cnt   <= win_nxt;
        end
    end

endmodule

// File: tb/tb_pong_game_engine.sv
// Self-checking bench: integer world model compared every cycle, plus hand-derived checkpoints.
module tb_pong_game_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       raket_up = 1'b0;
    logic       raket_down = 1'b0;
    logic [9:0] paddle_y, ai_y, ball_x, ball_y;
    logic [3:0] miss_cnt, win_cnt;
    logic [1:0] state;

    int n_chk  = 0;
    int n_pass = 0;
    int n_tick = 0;

    // Model of the world, in plain pixels.
    int m_py, m_ay, m_bx, m_by, m_dx, m_dy, m_st, m_serve, m_miss, m_win, m_left_lost;

    always #5 clk = ~clk;

    pong_game_engine dut (
        .inClock    (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .raket_up   (raket_up),
        .raket_down (raket_down),
        .paddle_y   (paddle_y),
        .ai_y       (ai_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .miss_cnt   (miss_cnt),
        .win_cnt    (win_cnt),
        .state      (state)
    );

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (tick %0d)", name, got, exp, n_tick);
    endtask

    task automatic model_reset();
        m_py = 208; m_ay = 208; m_bx = 316; m_by = 236;
        m_dx = 1; m_dy = 1; m_st = 0; m_serve = 0;
        m_miss = 0; m_win = 0; m_left_lost = 0;
        n_tick = 0;
    endtask

    task automatic model_step(input logic up, input logic dn);
        int nx, ny, old_by, old_py, old_ay, tgt;
        old_by = m_by; old_py = m_py; old_ay = m_ay; tgt = 0;
        if (up && !dn)      m_py = (old_py - 4 < 0) ? 0 : old_py - 4;
        else if (dn && !up) m_py = (old_py + 4 > 416) ? 416 : old_py + 4;
`ifdef PONG_AI_PADDLE_EN
        tgt = old_by + 4 - 32;
        if (tgt < old_ay)      m_ay = (old_ay - 2 < 0) ? 0 : old_ay - 2;
        else if (tgt > old_ay) m_ay = (old_ay + 2 > 416) ? 416 : old_ay + 2;
`endif
        if (m_st == 0) begin
            if (m_serve == 59) begin m_st = 1; m_serve = 0; end
            else m_serve++;
        end else if (m_st == 1) begin
            nx = m_bx + (m_dx != 0 ? 2 : -2);
            ny = m_by + (m_dy != 0 ? 2 : -2);
            if (ny <= 0)        begin m_by = 0;   m_dy = 1; end
            else if (ny >= 472) begin m_by = 472; m_dy = 0; end
            else m_by = ny;
            if (m_dx == 0 && nx <= 24 && m_bx >= 24 && old_by + 8 > old_py && old_by < old_py + 64) begin
                m_bx = 24; m_dx = 1;
            end else if (m_dx == 0 && nx <= 0) begin
                m_bx = 0; m_st = 2; m_left_lost = 1;
                if (m_miss < 15) m_miss++;
`ifdef PONG_AI_PADDLE_EN
            end else if (m_dx == 1 && nx >= 608 && m_bx <= 608 && old_by + 8 > old_ay && old_by < old_ay + 64) begin
                m_bx = 608; m_dx = 0;
            end else if (m_dx == 1 && nx >= 632) begin
                m_bx = 632; m_st = 2; m_left_lost = 0;
                if (m_win < 15) m_win++;
`else
            end else if (m_dx == 1 && nx >= 632) begin
                m_bx = 632; m_dx = 0;
`endif
            end else begin
                m_bx = nx;
            end
        end else begin
            m_bx = 316; m_by = 236; m_dx = m_left_lost; m_st = 0; m_serve = 0;
        end
    endtask

    task automatic cmp_model();
        logic [49:0] got, exp;
        got = {paddle_y, ai_y, ball_x, ball_y, miss_cnt, win_cnt, state};
        exp = {10'(m_py), 10'(m_ay), 10'(m_bx), 10'(m_by), 4'(m_miss), 4'(m_win), 2'(m_st)};
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL frame_state tick %0d: got py=%0d ay=%0d bx=%0d by=%0d miss=%0d win=%0d st=%0d, expected py=%0d ay=%0d bx=%0d by=%0d miss=%0d win=%0d st=%0d",
                      n_tick, paddle_y, ai_y, ball_x, ball_y, miss_cnt, win_cnt, state,
                      m_py, m_ay, m_bx, m_by, m_miss, m_win, m_st);
    endtask

    // Drive one clock cycle, advance the model alongside, compare after the edge.
    task automatic cycle(input logic rst, input logic tk, input logic up, input logic dn);
        reset = rst; frame_tick = tk; raket_up = up; raket_down = dn;
        @(posedge clk);
        if (rst) model_reset();
        else if (tk) begin model_step(up, dn); n_tick++; end
        #1;
        cmp_model();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_paddle_y"}, paddle_y, 208);
        check({tag, "_ai_y"},     ai_y,     208);
        check({tag, "_ball_x"},   ball_x,   316);
        check({tag, "_ball_y"},   ball_y,   236);
        check({tag, "_state"},    state,    0);
        check({tag, "_miss"},     miss_cnt, 0);
        check({tag, "_win"},      win_cnt,  0);
    endtask

    task automatic pins();
        case (n_tick)
            59:  begin check("serve_hold_state", state, 0); check("serve_hold_x", ball_x, 316); end
            60:  begin check("play_entry_state", state, 1); check("play_entry_y", ball_y, 236); end
            61:  begin check("first_move_x", ball_x, 318); check("first_move_y", ball_y, 238); end
            574: check("paddle_up_51", paddle_y, 4);
            575: check("paddle_top_52", paddle_y, 0);
            583: check("paddle_top_hold", paddle_y, 0);
            588: check("paddle_down", paddle_y, 20);
            598: check("paddle_both_keys", paddle_y, 20);
            608: check("paddle_top_again", paddle_y, 0);
`ifndef PONG_AI_PADDLE_EN
            178:  check("floor_clamp_y", ball_y, 472);
            179:  begin check("floor_bounce_y", ball_y, 470); check("floor_bounce_x", ball_x, 554); end
            218:  check("right_wall_x", ball_x, 632);
            219:  check("right_wall_bounce_x", ball_x, 630);
            522:  begin check("paddle_hit_x", ball_x, 24); check("paddle_hit_y", ball_y, 216); end
            523:  check("paddle_hit_out_x", ball_x, 26);
            1141: check("pre_miss_x", ball_x, 2);
            1142: begin check("miss_state", state, 2); check("miss_cnt_1", miss_cnt, 1); end
            1143: begin check("post_miss_state", state, 0); check("post_miss_x", ball_x, 316); end
            1677: check("miss_cnt_2", miss_cnt, 2);
            8632: check("miss_cnt_15", miss_cnt, 15);
            9702: begin check("miss_sat_state", state, 2); check("miss_cnt_sat", miss_cnt, 15); end
            9800: check("midplay_state", state, 1);
`endif
            default: ;
        endcase
    endtask

    initial begin
        int k;
        logic up, dn;
        model_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_reset_values("reset");
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("tick_in_reset_paddle", paddle_y, 208);

        // Serve with idle cycles between ticks; a held key must not move anything without a tick.
        for (int i = 0; i < 60; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            pins();
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Back-to-back frames with a scripted key schedule.
        while (n_tick < 9800) begin
            k  = n_tick + 1;
            up = ((k >= 524 && k <= 583) || (k >= 589 && k <= 608)) ? 1'b1 : 1'b0;
            dn = (k >= 584 && k <= 598) ? 1'b1 : 1'b0;
            cycle(1'b0, 1'b1, up, dn);
            pins();
        end

        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        check_reset_values("midplay_reset");
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("after_reset_serve", state, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
